// File: rtl/alu16_pkg.sv
// Shared types and constants for the ALU16 command issue stage.
package alu16_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam int CMD_W = 35;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
    } cmd_t;

    function automatic logic op_is_illegal(input logic [2:0] op);
        logic ill;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ill = 1'b0;
            default:                               ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/alu16_cmd_fifo.sv
// Command FIFO for the ALU16 issue stage; push is ignored when full, pop when empty.
module alu16_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == {CNT_W{1'b0}});
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/alu16_cmd_issue.sv
// Flow-controlled issue stage wrapping a combinational 16-bit ALU.
// Optional perf counters: define ALU16_ISSUE_PERF_EN.
module alu16_cmd_issue
    import alu16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [2:0]       alu_control,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [2:0]       rsp_op,
    output logic             rsp_zero,
    output logic             rsp_illegal,
`ifdef ALU16_ISSUE_PERF_EN
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall,
`endif
    output logic [CNT_W-1:0] fifo_count
);

    state_e      state_q, state_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_ctrl_q, alu_ctrl_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [2:0]  rsp_op_q, rsp_op_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    cmd_t        fifo_head;
    cmd_t        cmd_in;
    logic        cur_illegal;
    logic [15:0] cur_result;

    assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;

    alu16_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cur_illegal = op_is_illegal(alu_ctrl_q);
    assign cur_result  = cur_illegal ? 16'h0000 : alu_result;

    // Issue FSM: pop and drive the ALU, capture one cycle later, hold until accepted.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_op_d      = rsp_op_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        fifo_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    alu_a_d    = fifo_head.a;
                    alu_b_d    = fifo_head.b;
                    alu_ctrl_d = fifo_head.op;
                    state_d    = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                rsp_valid_d   = 1'b1;
                rsp_result_d  = cur_result;
                rsp_op_d      = alu_ctrl_q;
                rsp_zero_d    = (cur_result == 16'h0000);
                rsp_illegal_d = cur_illegal;
                state_d       = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        alu_a_d    = fifo_head.a;
                        alu_b_d    = fifo_head.b;
                        alu_ctrl_d = fifo_head.op;
                        state_d    = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // FSM, ALU-drive and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= 16'h0000;
            alu_b_q       <= 16'h0000;
            alu_ctrl_q    <= 3'b000;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 16'h0000;
            rsp_op_q      <= 3'b000;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_op_q      <= rsp_op_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;

`ifdef ALU16_ISSUE_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Handshake and stall counters, wrapping at 2^32.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (rsp_valid_q && rsp_ready) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end else begin
            perf_ops_d = perf_ops_q;
        end
        if (rsp_valid_q && !rsp_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu16_cmd_issue.sv
// Directed, table-driven bench for alu16_cmd_issue with a behavioural ALU16 model.
module tb_alu16_cmd_issue;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [2:0]  cmd_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_zero;
    logic        rsp_illegal;
    logic [2:0]  fifo_count;
`ifdef ALU16_ISSUE_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   n_rsp = 0;
    vec_t exp_q[$];
    int   hs_cyc[$];
    vec_t tbl[11];

    alu16_cmd_issue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_op      (rsp_op),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
`ifdef ALU16_ISSUE_PERF_EN
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall),
`endif
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU16bit; illegal codes return junk that the DUT must mask.
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = 16'hDEAD;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every response handshake must match the oldest outstanding command.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                fails++;
                tests++;
                $display("FAIL unexpected_rsp: got result %h, required no response", rsp_result);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e.res));
                check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                check("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
                check("rsp_op", 32'(rsp_op), 32'(e.op));
            end
            n_rsp++;
            hs_cyc.push_back(cyc);
        end
    end

    task automatic push(input vec_t v);
        int w = 0;
        cmd_a = v.a;
        cmd_b = v.b;
        cmd_op = v.op;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!cmd_ready) begin
            fails++;
            tests++;
            $display("FAIL push_timeout: cmd_ready got 0 required 1");
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back(v);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsps(input int target);
        int w = 0;
        while (n_rsp < target && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (n_rsp < target) begin
            fails++;
            tests++;
            $display("FAIL rsp_timeout: got %0d responses required %0d", n_rsp, target);
        end
    endtask

    initial begin
        int   w;
        int   base;
        int   seen;
        logic [15:0] held;
        vec_t extra;

        tbl[0]  = '{16'h0001, 16'h0001, 3'b000, 16'h0002, 1'b0, 1'b0};
        tbl[1]  = '{16'h0002, 16'h0001, 3'b001, 16'h0001, 1'b0, 1'b0};
        tbl[2]  = '{16'hFF00, 16'h0F0F, 3'b010, 16'h0F00, 1'b0, 1'b0};
        tbl[3]  = '{16'hFF00, 16'h0F0F, 3'b011, 16'hFF0F, 1'b0, 1'b0};
        tbl[4]  = '{16'hFF00, 16'h0F0F, 3'b100, 16'hF00F, 1'b0, 1'b0};
        tbl[5]  = '{16'h1234, 16'h0000, 3'b110, 16'h0000, 1'b1, 1'b1};
        tbl[6]  = '{16'h8000, 16'h8000, 3'b001, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0001, 3'b001, 16'hFFFF, 1'b0, 1'b0};
        tbl[9]  = '{16'h5A5A, 16'h5A5A, 3'b100, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{16'hFFFF, 16'hFFFF, 3'b111, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = 16'h0000;
        cmd_b = 16'h0000;
        cmd_op = 3'b000;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_alu_a", 32'(alu_a), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);

        // Single add: response visible two edges after the push edge.
        push(tbl[0]);
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("single_latency", 32'(w), 32'd2);
        wait_rsps(1);

        // Back-to-back burst with rsp_ready held high: one response every 2 cycles.
        base = hs_cyc.size();
        for (int k = 1; k <= 4; k++) push(tbl[k]);
        wait_rsps(5);
        for (int k = 1; k < 4; k++) begin
            if (hs_cyc.size() > base + k)
                check("burst_gap", 32'(hs_cyc[base + k] - hs_cyc[base + k - 1]), 32'd2);
        end

        // Full table, one command at a time.
        for (int k = 0; k < 11; k++) begin
            push(tbl[k]);
            wait_rsps(n_rsp + 1);
        end

        // Backpressure: one in HOLD, four queued, further pushes refused.
        rsp_ready = 1'b0;
        base = n_rsp;
        for (int k = 0; k < 5; k++) push(tbl[4 + k]);
        check("bp_fifo_count", 32'(fifo_count), 32'd4);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        held = rsp_result;
        check("bp_head_result", 32'(held), 32'(tbl[4].res));
        extra = tbl[9];
        cmd_a = extra.a;
        cmd_b = extra.b;
        cmd_op = extra.op;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_count_hold", 32'(fifo_count), 32'd4);
            check("bp_result_stable", 32'(rsp_result), 32'(held));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsps(base + 5);
        repeat (2) @(posedge clk);
        #1;
        check("bp_drained_count", 32'(fifo_count), 32'd0);
        check("bp_drained_valid", 32'(rsp_valid), 32'd0);
        check("bp_exp_empty", 32'(exp_q.size()), 32'd0);

        // Reset while in HOLD with two commands queued.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(tbl[k]);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
`ifdef ALU16_ISSUE_PERF_EN
        check("rst_perf_ops", perf_ops, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("no_stale_rsp", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
